blastn_task_writeback_unit: RTL and testbench

Downstream endpoint of the BLASTN control unit's 256-bit task stream. Accepts one seed task per handshake, forwards the seed to the ungapped-extension engine, then writes the four results (score, length, query start, database start) to the result addresses carried in the task. Pulses `done` once all four memory writes are acknowledged, releasing the control unit back to its configuration state.

---
 rtl/blastn_task_writeback_unit.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_blastn_task_writeback_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blastn_task_writeback_unit.sv
// blastn_task_writeback_unit
// Receives one 256-bit seed task from the control unit. It hands the seed to
// the ungapped-extension engine and waits for the result. It then writes
// score, length, query start and database start to the four result addresses
// carried in the task. A one-cycle done pulse follows the fourth write
// acknowledge. Handshake flags are registers. Message outputs are gated muxes
// of registers, so they read as zero whenever their valid is low.

package blastn_wb_pkg;

  // 4-byte memory request: type, opaque tag, byte address, length code, data.
  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  // 4-byte memory response. Only the handshake matters to this unit.
  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

endpackage

// Protocol invariants of the writeback unit, kept out of the datapath.
module blastn_task_writeback_unit_chk (
  input logic         clk,
  input logic         reset,
  input logic [2:0]   state,
  input logic         done,
  input logic         istream_rdy,
  input logic         ext_req_val,
  input logic [127:0] ext_req_msg,
  input logic         memreq_val,
  input logic         memreq_rdy,
  input logic [76:0]  memreq_msg,
  input logic [2:0]   wr_sent,
  input logic [2:0]   wr_acked
);

  // The completion pulse never lasts longer than one cycle.
  a_done_pulse: assert property (@(posedge clk) disable iff (reset)
    done |=> !done);

  // The task input is only offered while idle.
  a_rdy_idle: assert property (@(posedge clk) disable iff (reset)
    istream_rdy |-> (state == 3'd0));

  // A seed request is only offered from the send state.
  a_ext_state: assert property (@(posedge clk) disable iff (reset)
    ext_req_val |-> (state == 3'd1));

  // Write requests are only offered from the memory state.
  a_mem_state: assert property (@(posedge clk) disable iff (reset)
    memreq_val |-> (state == 3'd3));

  // Idle message buses are driven to zero.
  a_ext_zero: assert property (@(posedge clk) disable iff (reset)
    !ext_req_val |-> (ext_req_msg == 128'd0));

  a_mem_zero: assert property (@(posedge clk) disable iff (reset)
    !memreq_val |-> (memreq_msg == 77'd0));

  // A stalled write request keeps its message until it handshakes.
  a_mem_hold: assert property (@(posedge clk) disable iff (reset)
    (memreq_val && !memreq_rdy) |=> (memreq_val && $stable(memreq_msg)));

  // Acknowledges never outrun requests, and at most four requests go out.
  a_counters: assert property (@(posedge clk) disable iff (reset)
    (wr_acked <= wr_sent) && (wr_sent <= 3'd4));

endmodule

module blastn_task_writeback_unit
  import blastn_wb_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         istream_val,
  output logic         istream_rdy,
  input  logic [255:0] istream_msg,
  output logic         ext_req_val,
  input  logic         ext_req_rdy,
  output logic [127:0] ext_req_msg,
  input  logic         ext_resp_val,
  output logic         ext_resp_rdy,
  input  logic [127:0] ext_resp_msg,
  output logic         memreq_val,
  input  logic         memreq_rdy,
  output mem_req_4B_t  memreq_msg,
  input  logic         memresp_val,
  output logic         memresp_rdy,
  input  mem_resp_4B_t memresp_msg,
  output logic         done,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EXT_SEND = 3'd1,
    ST_EXT_WAIT = 3'd2,
    ST_MEM      = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t      state_r;

  // Task register: result addresses and seed fields.
  logic [31:0] db_pos_addr_r;
  logic [31:0] q_pos_addr_r;
  logic [31:0] len_addr_r;
  logic [31:0] score_addr_r;
  logic [31:0] db_pos_r;
  logic [31:0] q_pos_r;
  logic [31:0] db_seq_r;
  logic [31:0] query_seq_r;

  // Extension results.
  logic [31:0] db_start_r;
  logic [31:0] q_start_r;
  logic [31:0] len_r;
  logic [31:0] score_r;

  // Write progress in the memory state.
  logic [2:0]  wr_sent_r;
  logic [2:0]  wr_acked_r;

  // Registered handshake and status outputs.
  logic        istream_rdy_r;
  logic        ext_req_val_r;
  logic        ext_resp_rdy_r;
  logic        memreq_val_r;
  logic        memresp_rdy_r;
  logic        done_r;

  logic        in_fire_s;
  logic        ext_req_fire_s;
  logic        ext_resp_fire_s;
  logic        memreq_fire_s;
  logic        memresp_fire_s;
  logic        last_ack_s;
  logic        last_req_s;

  logic [31:0] wr_addr_s;
  logic [31:0] wr_data_s;
  mem_req_4B_t wr_msg_s;

  // Response contents are carried for tracing only.
  logic        memresp_unused_s;

  assign in_fire_s       = istream_rdy_r  & istream_val;
  assign ext_req_fire_s  = ext_req_val_r  & ext_req_rdy;
  assign ext_resp_fire_s = ext_resp_rdy_r & ext_resp_val;
  assign memreq_fire_s   = memreq_val_r   & memreq_rdy;
  assign memresp_fire_s  = memresp_rdy_r  & memresp_val;

  // The fourth acknowledge handshakes in this cycle, or the fourth request does.
  assign last_ack_s = memresp_fire_s & (wr_acked_r == 3'd3);
  assign last_req_s = memreq_fire_s  & (wr_sent_r  == 3'd3);

  assign memresp_unused_s = ^memresp_msg;

  // Control FSM: state, task and result capture, counters, registered handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      db_pos_addr_r  <= 32'd0;
      q_pos_addr_r   <= 32'd0;
      len_addr_r     <= 32'd0;
      score_addr_r   <= 32'd0;
      db_pos_r       <= 32'd0;
      q_pos_r        <= 32'd0;
      db_seq_r       <= 32'd0;
      query_seq_r    <= 32'd0;
      db_start_r     <= 32'd0;
      q_start_r      <= 32'd0;
      len_r          <= 32'd0;
      score_r        <= 32'd0;
      wr_sent_r      <= 3'd0;
      wr_acked_r     <= 3'd0;
      istream_rdy_r  <= 1'b1;
      ext_req_val_r  <= 1'b0;
      ext_resp_rdy_r <= 1'b0;
      memreq_val_r   <= 1'b0;
      memresp_rdy_r  <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_fire_s) begin
            db_pos_addr_r <= istream_msg[255:224];
            q_pos_addr_r  <= istream_msg[223:192];
            len_addr_r    <= istream_msg[191:160];
            score_addr_r  <= istream_msg[159:128];
            db_pos_r      <= istream_msg[127:96];
            q_pos_r       <= istream_msg[95:64];
            db_seq_r      <= istream_msg[63:32];
            query_seq_r   <= istream_msg[31:0];
            istream_rdy_r <= 1'b0;
            ext_req_val_r <= 1'b1;
            state_r       <= ST_EXT_SEND;
          end
        end
        ST_EXT_SEND: begin
          if (ext_req_fire_s) begin
            ext_req_val_r  <= 1'b0;
            ext_resp_rdy_r <= 1'b1;
            state_r        <= ST_EXT_WAIT;
          end
        end
        ST_EXT_WAIT: begin
          if (ext_resp_fire_s) begin
            db_start_r     <= ext_resp_msg[127:96];
            q_start_r      <= ext_resp_msg[95:64];
            len_r          <= ext_resp_msg[63:32];
            score_r        <= ext_resp_msg[31:0];
            wr_sent_r      <= 3'd0;
            wr_acked_r     <= 3'd0;
            ext_resp_rdy_r <= 1'b0;
            memreq_val_r   <= 1'b1;
            memresp_rdy_r  <= 1'b1;
            state_r        <= ST_MEM;
          end
        end
        ST_MEM: begin
          // Requests and acknowledges are counted independently, so both may
          // advance on the same edge.
          if (memreq_fire_s) begin
            wr_sent_r <= wr_sent_r + 3'd1;
          end
          if (last_req_s) begin
            memreq_val_r <= 1'b0;
          end
          if (memresp_fire_s) begin
            wr_acked_r <= wr_acked_r + 3'd1;
          end
          if (last_ack_s) begin
            memreq_val_r  <= 1'b0;
            memresp_rdy_r <= 1'b0;
            done_r        <= 1'b1;
            state_r       <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r        <= 1'b0;
          istream_rdy_r <= 1'b1;
          state_r       <= ST_IDLE;
        end
        default: begin
          // Unused encodings recover to a clean idle.
          istream_rdy_r  <= 1'b1;
          ext_req_val_r  <= 1'b0;
          ext_resp_rdy_r <= 1'b0;
          memreq_val_r   <= 1'b0;
          memresp_rdy_r  <= 1'b0;
          done_r         <= 1'b0;
          state_r        <= ST_IDLE;
        end
      endcase
    end
  end

  // Select the address/data pair for the write currently being offered.
  always_comb begin
    wr_addr_s = score_addr_r;
    wr_data_s = score_r;
    case (wr_sent_r[1:0])
      2'd0: begin
        wr_addr_s = score_addr_r;
        wr_data_s = score_r;
      end
      2'd1: begin
        wr_addr_s = len_addr_r;
        wr_data_s = len_r;
      end
      2'd2: begin
        wr_addr_s = q_pos_addr_r;
        wr_data_s = q_start_r;
      end
      2'd3: begin
        wr_addr_s = db_pos_addr_r;
        wr_data_s = db_start_r;
      end
      default: begin
        wr_addr_s = score_addr_r;
        wr_data_s = score_r;
      end
    endcase
  end

  // Assemble the 4-byte write request. The opaque tag is the write index.
  always_comb begin
    wr_msg_s        = '0;
    wr_msg_s.type_  = MEM_TYPE_WRITE;
    wr_msg_s.opaque = {5'd0, wr_sent_r};
    wr_msg_s.addr   = wr_addr_s;
    wr_msg_s.len    = 2'd0;
    wr_msg_s.data   = wr_data_s;
  end

  assign istream_rdy  = istream_rdy_r;
  assign ext_req_val  = ext_req_val_r;
  assign ext_resp_rdy = ext_resp_rdy_r;
  assign memreq_val   = memreq_val_r;
  assign memresp_rdy  = memresp_rdy_r;
  assign done         = done_r;
  assign state        = state_r;

  assign ext_req_msg = ext_req_val_r ? {db_pos_r, q_pos_r, db_seq_r, query_seq_r} : 128'd0;
  assign memreq_msg  = memreq_val_r  ? wr_msg_s : '0;

  blastn_task_writeback_unit_chk u_chk (
    .clk         (clk),
    .reset       (reset),
    .state       (state),
    .done        (done),
    .istream_rdy (istream_rdy),
    .ext_req_val (ext_req_val),
    .ext_req_msg (ext_req_msg),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memreq_msg  (memreq_msg),
    .wr_sent     (wr_sent_r),
    .wr_acked    (wr_acked_r)
  );

endmodule

// File: tb/tb_blastn_task_writeback_unit.sv
// Self-checking bench for blastn_task_writeback_unit: scoreboard of expected
// seed requests and memory writes, plus extension and memory partner models.
`timescale 1ns/1ps
module tb_blastn_task_writeback_unit;
  import blastn_wb_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         istream_val;
  logic         istream_rdy;
  logic [255:0] istream_msg;
  logic         ext_req_val;
  logic         ext_req_rdy;
  logic [127:0] ext_req_msg;
  logic         ext_resp_val;
  logic         ext_resp_rdy;
  logic [127:0] ext_resp_msg;
  logic         memreq_val;
  logic         memreq_rdy;
  mem_req_4B_t  memreq_msg;
  logic         memresp_val;
  logic         memresp_rdy;
  mem_resp_4B_t memresp_msg;
  logic         done;
  logic [2:0]   state;

  blastn_task_writeback_unit dut (
    .clk          (clk),
    .reset        (reset),
    .istream_val  (istream_val),
    .istream_rdy  (istream_rdy),
    .istream_msg  (istream_msg),
    .ext_req_val  (ext_req_val),
    .ext_req_rdy  (ext_req_rdy),
    .ext_req_msg  (ext_req_msg),
    .ext_resp_val (ext_resp_val),
    .ext_resp_rdy (ext_resp_rdy),
    .ext_resp_msg (ext_resp_msg),
    .memreq_val   (memreq_val),
    .memreq_rdy   (memreq_rdy),
    .memreq_msg   (memreq_msg),
    .memresp_val  (memresp_val),
    .memresp_rdy  (memresp_rdy),
    .memresp_msg  (memresp_msg),
    .done         (done),
    .state        (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Partner behaviour knobs.
  int ext_bp = 0, mem_bp = 0, resp_lat_max = 0, mem_lat_max = 0;
  bit late_acks = 1'b0;

  // Scoreboard queues.
  logic [127:0] exp_ext_q[$];
  logic [127:0] resp_q[$];
  mem_req_4B_t  exp_wr_q[$];

  // Monitor bookkeeping.
  int done_cnt = 0, both_fire_cnt = 0;
  int rdy_viol = 0, zero_viol = 0, done_long_viol = 0;
  int acc_cyc = 0, done_cyc = 0, first_extreq_cyc = -1;
  int first_wr_cyc = -1, last_wr_cyc = 0, first_ack_cyc = -1, last_ack_cyc = 0;
  int task_req_cnt = 0, task_ack_cnt = 0;
  bit busy = 1'b0, prev_done = 1'b0;

  function automatic mem_req_4B_t mk_wr(input int idx, input logic [31:0] addr, input logic [31:0] data);
    mem_req_4B_t m;
    m.type_  = 3'd1;
    m.opaque = 8'(idx);
    m.addr   = addr;
    m.len    = 2'd0;
    m.data   = data;
    return m;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Monitor: observes handshakes at the falling edge and checks the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (istream_val && istream_rdy) begin
          acc_cyc = cyc; busy = 1'b1;
          first_extreq_cyc = -1; first_wr_cyc = -1; first_ack_cyc = -1;
          task_req_cnt = 0; task_ack_cnt = 0;
        end else if (busy && istream_rdy) begin
          rdy_viol++;
        end
        if (ext_req_val && first_extreq_cyc < 0) first_extreq_cyc = cyc;
        if (!ext_req_val && ext_req_msg !== 128'd0) zero_viol++;
        if (!memreq_val && memreq_msg !== '0) zero_viol++;
        if (ext_req_val && ext_req_rdy) begin
          if (exp_ext_q.size() == 0) check_value("ext_req_unexpected", 1, 0);
          else check_value("ext_req_msg", ext_req_msg, exp_ext_q.pop_front());
        end
        if (memreq_val && memreq_rdy) begin
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
          last_wr_cyc = cyc;
          task_req_cnt++;
          if (exp_wr_q.size() == 0) check_value("memreq_unexpected", 1, 0);
          else check_value("memreq_msg", memreq_msg, exp_wr_q.pop_front());
        end
        if (memresp_val && memresp_rdy) begin
          if (first_ack_cyc < 0) first_ack_cyc = cyc;
          last_ack_cyc = cyc;
          task_ack_cnt++;
          if (memreq_val && memreq_rdy) both_fire_cnt++;
        end
        if (done) begin
          if (prev_done) done_long_viol++;
          done_cnt++;
          done_cyc = cyc;
          check_value("reqs_at_done", task_req_cnt, 4);
          check_value("acks_at_done", task_ack_cnt, 4);
          busy = 1'b0;
        end
        prev_done = done;
      end
    end
  end

  // Extension engine model: accepts seeds, answers after a random latency.
  bit ext_pending = 1'b0, ext_rst = 1'b0, ext_rq = 1'b0, ext_rs = 1'b0;
  int ext_lat = 0;
  logic [127:0] ext_data;
  initial begin
    ext_req_rdy = 1'b0; ext_resp_val = 1'b0; ext_resp_msg = 128'd0; ext_data = 128'd0;
    forever begin
      @(negedge clk);
      ext_rst = reset;
      ext_rq  = ext_req_val && ext_req_rdy;
      ext_rs  = ext_resp_val && ext_resp_rdy;
      if (ext_rst) begin
        ext_pending = 1'b0;
      end else if (ext_rq) begin
        ext_pending = 1'b1;
        ext_lat = $urandom_range(resp_lat_max, 0);
        ext_data = (resp_q.size() > 0) ? resp_q.pop_front() : 128'd0;
      end
      @(posedge clk); #1;
      if (ext_rst || ext_rs) ext_resp_val = 1'b0;
      if (!ext_rst && ext_pending && !ext_resp_val) begin
        if (ext_lat == 0) begin
          ext_resp_val = 1'b1; ext_resp_msg = ext_data; ext_pending = 1'b0;
        end else begin
          ext_lat--;
        end
      end
      ext_req_rdy = ($urandom_range(99, 0) >= ext_bp);
    end
  end

  // Memory model: acknowledges each write in order after a random latency.
  int ack_due_q[$];
  logic [7:0] ack_op_q[$];
  bit ack_release = 1'b0, m_rst = 1'b0, m_rq = 1'b0, m_rs = 1'b0;
  mem_resp_4B_t ack_tmp;
  initial begin
    memreq_rdy = 1'b0; memresp_val = 1'b0; memresp_msg = '0;
    forever begin
      @(negedge clk);
      m_rst = reset;
      m_rq  = memreq_val && memreq_rdy;
      m_rs  = memresp_val && memresp_rdy;
      if (m_rst) begin
        ack_due_q.delete(); ack_op_q.delete(); ack_release = 1'b0;
      end else if (m_rq) begin
        ack_due_q.push_back(cyc + 1 + $urandom_range(mem_lat_max, 0));
        ack_op_q.push_back(memreq_msg.opaque);
      end
      @(posedge clk); #1;
      if (m_rst || m_rs) memresp_val = 1'b0;
      if (late_acks && ack_due_q.size() >= 4) ack_release = 1'b1;
      if (!m_rst && !memresp_val && ack_due_q.size() > 0 &&
          (!late_acks || ack_release) && cyc >= ack_due_q[0]) begin
        ack_tmp = '0;
        ack_tmp.type_  = 3'd1;
        ack_tmp.opaque = ack_op_q.pop_front();
        void'(ack_due_q.pop_front());
        memresp_msg = ack_tmp;
        memresp_val = 1'b1;
      end
      if (ack_due_q.size() == 0 && !memresp_val) ack_release = 1'b0;
      memreq_rdy = ($urandom_range(99, 0) >= mem_bp);
    end
  end

  task automatic push_expect(input logic [255:0] msg, input logic [127:0] resp);
    exp_ext_q.push_back(msg[127:0]);
    resp_q.push_back(resp);
    exp_wr_q.push_back(mk_wr(0, msg[159:128], resp[31:0]));
    exp_wr_q.push_back(mk_wr(1, msg[191:160], resp[63:32]));
    exp_wr_q.push_back(mk_wr(2, msg[223:192], resp[95:64]));
    exp_wr_q.push_back(mk_wr(3, msg[255:224], resp[127:96]));
  endtask

  task automatic drive_task(input logic [255:0] msg);
    int n;
    bit acc;
    n = 0; acc = 1'b0;
    @(posedge clk); #1;
    istream_val = 1'b1; istream_msg = msg;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = istream_rdy;
      n++;
      if (!acc) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    istream_val = 1'b0;
    istream_msg = rand256();
    check_value("istream_accept", acc, 1);
  endtask

  task automatic run_task(input logic [255:0] msg, input logic [127:0] resp);
    int d0, n;
    d0 = done_cnt; n = 0;
    push_expect(msg, resp);
    drive_task(msg);
    while (done_cnt == d0 && n < 3000) begin @(negedge clk); n++; end
    @(negedge clk); @(negedge clk);
    check_value("done_once", done_cnt - d0, 1);
    check_value("writes_drained", exp_wr_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [255:0] t1_msg;
  logic [127:0] t1_resp;
  int d0, n, bf0;

  initial begin
    reset = 1'b1; istream_val = 1'b0; istream_msg = 256'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst_done", done, 0);
    check_value("rst_ext_req_val", ext_req_val, 0);
    check_value("rst_ext_resp_rdy", ext_resp_rdy, 0);
    check_value("rst_memreq_val", memreq_val, 0);
    check_value("rst_memresp_rdy", memresp_rdy, 0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check_value("post_rst_istream_rdy", istream_rdy, 1);
    check_value("post_rst_state", state, 0);

    // Directed task, all partners ready, 1-cycle memory.
    t1_msg  = {32'h2300, 32'h2200, 32'h2100, 32'h2000, 32'd7, 32'd3, 32'h2C, 32'h1B};
    t1_resp = {32'd5, 32'd1, 32'd9, 32'd18};
    bf0 = both_fire_cnt;
    run_task(t1_msg, t1_resp);
    check_value("t1_extreq_cycle", first_extreq_cyc - acc_cyc, 1);
    check_value("t1_first_wr_cycle", first_wr_cyc - acc_cyc, 3);
    check_value("t1_last_wr_cycle", last_wr_cyc - acc_cyc, 6);
    check_value("t1_last_ack_cycle", last_ack_cyc - acc_cyc, 7);
    check_value("t1_done_cycle", done_cyc - acc_cyc, 8);
    check_value("same_cycle_fires", both_fire_cnt - bf0, 3);

    // Random back-pressure and latencies.
    ext_bp = 40; mem_bp = 40; resp_lat_max = 5; mem_lat_max = 5;
    for (int i = 0; i < 3; i++) run_task(rand256(), {$urandom(), $urandom(), $urandom(), $urandom()});

    // Late acknowledges: memory holds all acks until four requests are out.
    ext_bp = 0; mem_bp = 0; resp_lat_max = 0; mem_lat_max = 0; late_acks = 1'b1;
    run_task(rand256(), {$urandom(), $urandom(), $urandom(), $urandom()});
    check_value("late_first_ack_after_reqs", first_ack_cyc > last_wr_cyc, 1);
    check_value("late_done_after_4th_ack", done_cyc - last_ack_cyc, 1);
    late_acks = 1'b0;

    // Reset while in MEM with two writes sent.
    d0 = done_cnt; n = 0;
    push_expect(rand256(), {$urandom(), $urandom(), $urandom(), $urandom()});
    drive_task(exp_ext_q[0] == 128'd0 ? 256'd0 : {exp_wr_q[3].addr, exp_wr_q[2].addr,
               exp_wr_q[1].addr, exp_wr_q[0].addr, exp_ext_q[0]});
    while (task_req_cnt < 2 && n < 200) begin @(negedge clk); n++; end
    check_value("rst_reach_two_writes", task_req_cnt, 2);
    @(posedge clk); #1;
    check_value("rst_pre_index", memreq_msg.opaque, 2);
    check_value("rst_pre_state", state, 3);
    reset = 1'b1;
    exp_ext_q.delete(); resp_q.delete(); exp_wr_q.delete();
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check_value("rst_mem_state", state, 0);
    check_value("rst_mem_istream_rdy", istream_rdy, 1);
    check_value("rst_mem_done", done, 0);
    repeat (5) @(negedge clk);
    check_value("rst_mem_no_done", done_cnt - d0, 0);
    run_task(rand256(), {$urandom(), $urandom(), $urandom(), $urandom()});

    // Ten back-to-back tasks with moderate random delays.
    ext_bp = 20; mem_bp = 20; resp_lat_max = 3; mem_lat_max = 3;
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) run_task(rand256(), {$urandom(), $urandom(), $urandom(), $urandom()});
    check_value("ten_done_pulses", done_cnt - d0, 10);

    check_value("istream_rdy_while_busy", rdy_viol, 0);
    check_value("idle_msgs_zero", zero_viol, 0);
    check_value("done_single_cycle", done_long_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
